// File: rtl/prince_masked_rb.sv
// Round-based PRINCE encrypt/decrypt engine, first-order Boolean masked (two shares).
// One cipher step per clock; S-layers evaluated as DOM-style products on the shares.
module prince_masked_rb (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic         Dec_EncBar,
    input  logic [287:0] PRNG,
    input  logic [63:0]  inp_share0,
    input  logic [63:0]  inp_share1,
    input  logic [127:0] key,
    output logic [63:0]  out_share0,
    output logic [63:0]  out_share1,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [63:0] ALPHA  = 64'hc0ac29b7c97c50dd;
    localparam logic [63:0] S_TBL  = 64'h4D5E087619CA23FB;
    localparam logic [63:0] SI_TBL = 64'h1CE5046A98DF237B;

    // Algebraic normal form of a 4-bit table: coefficient vector of monomial m at [4m+:4].
    function automatic logic [63:0] anf_of(input logic [63:0] tbl);
        logic [63:0] res;
        logic [3:0]  acc;
        res = '0;
        for (int unsigned m = 0; m < 16; m++) begin
            acc = '0;
            for (int unsigned x = 0; x < 16; x++)
                if ((x & ~m & 32'hF) == 0) acc ^= tbl[4*x +: 4];
            res[4*m +: 4] = acc;
        end
        return res;
    endfunction

    localparam logic [63:0] S_ANF  = anf_of(S_TBL);
    localparam logic [63:0] SI_ANF = anf_of(SI_TBL);

    function automatic logic [63:0] rc(input logic [3:0] i);
        case (i)
            4'd0:    return 64'h0000000000000000;
            4'd1:    return 64'h13198a2e03707344;
            4'd2:    return 64'ha4093822299f31d0;
            4'd3:    return 64'h082efa98ec4e6c89;
            4'd4:    return 64'h452821e638d01377;
            4'd5:    return 64'hbe5466cf34e90c6c;
            4'd6:    return 64'h7ef84f78fd955cb1;
            4'd7:    return 64'h85840851f1ac43aa;
            4'd8:    return 64'hc882d32f25323c54;
            4'd9:    return 64'h64a51195e0e3610d;
            4'd10:   return 64'hd3b5a399ca0c2399;
            4'd11:   return 64'hc0ac29b7c97c50dd;
            default: return '0;
        endcase
    endfunction

    // Returns {z1, z0}; cross terms are blinded by r before meeting the other share.
    function automatic logic [1:0] dom_and(input logic a0, input logic a1,
                                           input logic b0, input logic b1, input logic r);
        return {(a1 & b1) ^ ((a1 & b0) ^ r), (a0 & b0) ^ ((a0 & b1) ^ r)};
    endfunction

    // r[3:0] input refresh, r[9:4] quadratic, r[13:10] cubic, r[17:14] output refresh.
    function automatic logic [7:0] masked_sbox(input logic [3:0] x0, input logic [3:0] x1,
                                               input logic [17:0] r, input logic [63:0] anf);
        logic [3:0]  a0, a1, y0, y1;
        logic [15:0] m0, m1;
        a0 = x0 ^ r[3:0];
        a1 = x1 ^ r[3:0];
        m0 = '0;
        m1 = '0;
        m0[0] = 1'b1;
        m0[1] = a0[0]; m1[1] = a1[0];
        m0[2] = a0[1]; m1[2] = a1[1];
        m0[4] = a0[2]; m1[4] = a1[2];
        m0[8] = a0[3]; m1[8] = a1[3];
        {m1[3],  m0[3]}  = dom_and(a0[0], a1[0], a0[1], a1[1], r[4]);
        {m1[5],  m0[5]}  = dom_and(a0[0], a1[0], a0[2], a1[2], r[5]);
        {m1[9],  m0[9]}  = dom_and(a0[0], a1[0], a0[3], a1[3], r[6]);
        {m1[6],  m0[6]}  = dom_and(a0[1], a1[1], a0[2], a1[2], r[7]);
        {m1[10], m0[10]} = dom_and(a0[1], a1[1], a0[3], a1[3], r[8]);
        {m1[12], m0[12]} = dom_and(a0[2], a1[2], a0[3], a1[3], r[9]);
        {m1[7],  m0[7]}  = dom_and(m0[3], m1[3], a0[2], a1[2], r[10]);
        {m1[11], m0[11]} = dom_and(m0[3], m1[3], a0[3], a1[3], r[11]);
        {m1[13], m0[13]} = dom_and(m0[5], m1[5], a0[3], a1[3], r[12]);
        {m1[14], m0[14]} = dom_and(m0[6], m1[6], a0[3], a1[3], r[13]);
        y0 = r[17:14];
        y1 = r[17:14];
        for (int unsigned m = 0; m < 16; m++) begin
            y0 ^= anf[4*m +: 4] & {4{m0[m]}};
            y1 ^= anf[4*m +: 4] & {4{m1[m]}};
        end
        return {y1, y0};
    endfunction

    function automatic logic [127:0] s_layer(input logic [63:0] s0, input logic [63:0] s1,
                                             input logic [287:0] rnd, input logic [63:0] anf);
        logic [63:0] o0, o1;
        logic [7:0]  y;
        o0 = '0;
        o1 = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            y = masked_sbox(s0[4*i +: 4], s1[4*i +: 4], rnd[18*i +: 18], anf);
            o0[4*i +: 4] = y[3:0];
            o1[4*i +: 4] = y[7:4];
        end
        return {o1, o0};
    endfunction

    // Nibble n counted from the MSB; columns are 16-bit chunks, chunk 0 = bits 63:48.
    function automatic logic [63:0] m_prime(input logic [63:0] x);
        logic [63:0] y;
        logic [3:0]  acc;
        int unsigned off;
        y = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            off = (c == 1 || c == 2) ? 32'd1 : 32'd0;
            for (int unsigned i = 0; i < 4; i++) begin
                acc = '0;
                for (int unsigned j = 0; j < 4; j++)
                    acc ^= x[63-16*c-4*j -: 4] & (4'hF ^ (4'h8 >> ((i + j + off) % 4)));
                y[63-16*c-4*i -: 4] = acc;
            end
        end
        return y;
    endfunction

    function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
        logic [63:0] y;
        int unsigned src;
        y = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                y[63-16*c-4*r -: 4] = x[63-16*src-4*r -: 4];
            end
        return y;
    endfunction

    fsm_t        state;
    logic [3:0]  cnt;
    logic        dec_q;
    logic [63:0] st0, st1, nxt0, nxt1;
    logic [63:0] k0, k1, k0p, k1p, kout, k1p_go, kin_go;
    logic [127:0] sl, mid;

    always_comb begin
        k0     = key[127:64];
        k1     = key[63:0];
        k0p    = {k0[0], k0[63:1]} ^ {63'd0, k0[63]};
        k1p_go = Dec_EncBar ? (k1 ^ ALPHA) : k1;
        kin_go = Dec_EncBar ? k0p : k0;
        k1p    = dec_q ? (k1 ^ ALPHA) : k1;
        kout   = dec_q ? k0 : k0p;
    end

    always_comb begin
        sl   = '0;
        mid  = '0;
        nxt0 = st0;
        nxt1 = st1;
        if (cnt <= 4'd5) begin
            sl   = s_layer(st0, st1, PRNG, S_ANF);
            nxt0 = shift_rows(m_prime(sl[63:0]), 1'b0) ^ rc(cnt) ^ k1p;
            nxt1 = shift_rows(m_prime(sl[127:64]), 1'b0);
        end else if (cnt == 4'd6) begin
            // Second S-layer of the middle step draws on the PRNG word with its halves swapped.
            mid  = s_layer(st0, st1, PRNG, S_ANF);
            sl   = s_layer(m_prime(mid[63:0]), m_prime(mid[127:64]),
                           {PRNG[143:0], PRNG[287:144]}, SI_ANF);
            nxt0 = sl[63:0];
            nxt1 = sl[127:64];
        end else if (cnt <= 4'd11) begin
            sl   = s_layer(m_prime(shift_rows(st0 ^ rc(cnt - 4'd1) ^ k1p, 1'b1)),
                           m_prime(shift_rows(st1, 1'b1)), PRNG, SI_ANF);
            nxt0 = sl[63:0];
            nxt1 = sl[127:64];
        end else begin
            nxt0 = st0 ^ rc(4'd11) ^ k1p ^ kout;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dec_q      <= 1'b0;
            st0        <= '0;
            st1        <= '0;
            out_share0 <= '0;
            out_share1 <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        dec_q <= Dec_EncBar;
                        st0   <= inp_share0 ^ kin_go ^ k1p_go ^ rc(4'd0);
                        st1   <= inp_share1;
                        cnt   <= 4'd1;
                        done  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    st0 <= nxt0;
                    st1 <= nxt1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd12) begin
                        out_share0 <= nxt0;
                        out_share1 <= nxt1;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prince_masked_rb.sv
// Directed bench for prince_masked_rb: known PRINCE vectors, mask/PRNG independence,
// reset abort and go-during-run behaviour.
module tb_prince_masked_rb;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         go = 1'b0;
    logic         dec_encbar = 1'b0;
    logic [287:0] prng = '0;
    logic [63:0]  in0 = '0;
    logic [63:0]  in1 = '0;
    logic [127:0] key = '0;
    logic [63:0]  out0, out1;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] CT_ZERO = 64'h818665aa0d02dfda;
    localparam logic [63:0] CT_ONES = 64'h604ae6ca03c20ada;
    localparam logic [63:0] PT_K1   = 64'h0123456789abcdef;
    localparam logic [63:0] CT_K1   = 64'hae25ad3ca8fa9ccf;

    prince_masked_rb dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .Dec_EncBar (dec_encbar),
        .PRNG       (prng),
        .inp_share0 (in0),
        .inp_share1 (in1),
        .key        (key),
        .out_share0 (out0),
        .out_share1 (out1),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    always @(negedge clk)
        for (int i = 0; i < 9; i++) prng[32*i +: 32] = $urandom;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts one operation and waits (bounded) for done; lat = edge number of done, 0 on timeout.
    task automatic run_op(input logic d, input logic [63:0] s0, input logic [63:0] s1,
                          input logic [127:0] k, output logic [63:0] res, output int lat);
        @(negedge clk);
        go = 1'b1; dec_encbar = d; in0 = s0; in1 = s1; key = k;
        @(posedge clk); #1;
        go = 1'b0; in0 = rand64(); in1 = rand64(); dec_encbar = ~d;
        check("done_drop", {63'd0, done}, 64'd0);
        lat = 0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        res = out0 ^ out1;
    endtask

    initial begin
        logic [63:0] res, m;
        int lat, rises, first, hi;
        logic prev;

        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_out0", out0, 64'd0);
        check("rst_out1", out1, 64'd0);
        @(negedge clk) reset = 1'b1;

        run_op(1'b0, 64'd0, 64'd0, 128'd0, res, lat);
        check("enc_zero", res, CT_ZERO);
        check("latency", 64'(lat), 64'd13);
        repeat (4) @(posedge clk);
        #1;
        check("hold_done", {63'd0, done}, 64'd1);
        check("hold_out", out0 ^ out1, CT_ZERO);

        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("pulse_done", {63'd0, done}, 64'd0);
        check("pulse_out0", out0, 64'd0);
        @(negedge clk) reset = 1'b1;

        run_op(1'b0, {16{4'hE}}, {16{4'h1}}, 128'd0, res, lat);
        check("enc_ones", res, CT_ONES);
        run_op(1'b1, CT_ONES, 64'd0, 128'd0, res, lat);
        check("dec_ones", res, {64{1'b1}});
        check("dec_latency", 64'(lat), 64'd13);

        for (int i = 0; i < 100; i++) begin
            m = rand64();
            run_op(1'b0, PT_K1 ^ m, m, {64'd0, 64'hfedcba9876543210}, res, lat);
            check("enc_k1_masked", res, CT_K1);
        end

        // abort at round 6
        @(negedge clk);
        go = 1'b1; dec_encbar = 1'b0; in0 = 64'd0; in1 = 64'd0; key = '0;
        @(posedge clk); #1 go = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_out0", out0, 64'd0);
        check("abort_out1", out1, 64'd0);
        @(negedge clk) reset = 1'b1;
        hi = 0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            if (done) hi++;
        end
        check("abort_no_done", 64'(hi), 64'd0);
        run_op(1'b0, 64'd0, 64'd0, 128'd0, res, lat);
        check("after_abort", res, CT_ZERO);
        check("after_abort_lat", 64'(lat), 64'd13);

        // go pulsed during RUN must be ignored
        @(negedge clk);
        go = 1'b1; dec_encbar = 1'b0; in0 = {16{4'hE}}; in1 = {16{4'h1}};
        @(posedge clk); #1;
        go = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        go = 1'b1; in0 = 64'd0; in1 = 64'd0; dec_encbar = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        rises = 0; first = 0; prev = done;
        for (int n = 6; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done && !prev) begin
                rises++;
                if (first == 0) first = n;
            end
            prev = done;
        end
        check("ign_rises", 64'(rises), 64'd1);
        check("ign_first", 64'(first), 64'd13);
        check("ign_result", out0 ^ out1, CT_ONES);
        check("ign_hold", {63'd0, done}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
